// File: rtl/i281_fetch_decode.sv
// i281 instruction fetch/decode front end: owns the program counter, fetches 16-bit words from the
// parallel code bus and presents them, fields split out, to the execute stage under valid/ready.
module i281_fetch_decode #(
    parameter int ADDR_W   = 4,
    parameter int RESET_PC = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [16*(2**ADDR_W)-1:0] code_bus,
    input  logic                      run,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [15:0]               instr,
    output logic [3:0]                opcode,
    output logic [1:0]                rx,
    output logic [1:0]                ry,
    output logic [7:0]                imm,
    output logic [ADDR_W:0]           imm_sext,
    output logic [ADDR_W-1:0]         instr_pc,
    output logic                      pc_wrap,
    output logic [15:0]               fetch_count
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W+3:0]   word_base;
    logic [15:0]         word;
    logic                transfer;
    logic                fetch;
    logic                pc_load;
    logic                clear_valid;

    assign transfer  = instr_valid & instr_ready;
    assign word_base = {pc, 4'b0000};
    assign word      = code_bus[word_base +: 16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A redirect outranks everything except in IDLE, where it only repositions the PC.
    always_comb begin
        next_state  = state;
        fetch       = 1'b0;
        pc_load     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                end else if (run) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_load     = 1'b1;
                    clear_valid = 1'b1;
                    next_state  = FLUSH;
                end else if (run) begin
                    fetch      = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_load     = 1'b1;
                    clear_valid = 1'b1;
                    next_state  = FLUSH;
                end else if (transfer) begin
                    if (run) begin
                        fetch = 1'b1;
                    end else begin
                        clear_valid = 1'b1;
                        next_state  = FETCH;
                    end
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    pc_load     = 1'b1;
                    clear_valid = 1'b1;
                end else if (run) begin
                    fetch      = 1'b1;
                    next_state = HOLD;
                end else begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= ADDR_W'(RESET_PC);
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            pc_wrap     <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc_wrap <= 1'b0;
            if (transfer && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (pc_load) begin
                pc <= redirect_pc;
            end else if (fetch) begin
                pc      <= pc + 1'b1;
                pc_wrap <= (pc == '1);
            end
            if (fetch) begin
                instr       <= word;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if (clear_valid) begin
                instr_valid <= 1'b0;
            end
        end
    end

    // Decode is pure field slicing of the registered word.
    assign opcode   = instr[15:12];
    assign rx       = instr[11:10];
    assign ry       = instr[9:8];
    assign imm      = instr[7:0];
    assign imm_sext = {instr[7], instr[ADDR_W-1:0]};

endmodule
